mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the IF stage (fetch requester) and the MEM stage (load/store requester) of the 5-stage pipeline. It sequences fixed-latency memory accesses with a small FSM and returns read data with a one-cycle done pulse. It also generates stall_if and stall_mem, which feed the PC/IF-ID write-enable logic alongside the load-use hazard unit.

Parameters:
ADDR_W, 32, address width of requesters and memory
DATA_W, 32, data width (must be 32; wstrb is 4 bits)
LATENCY, 2, memory access cycles, >= 1
MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits (only with ARB_FAIRNESS_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
i_req  in  1  fetch request, held until i_done or withdrawn
i_addr  in  ADDR_W  fetch address, stable while i_req
if_flush  in  1  discard in-flight fetch (branch/jump taken)
i_rdata  out  DATA_W  fetched instruction, valid when i_done
i_done  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  4  store byte enables
d_rdata  out  DATA_W  load data, valid when d_done
d_done  out  1  one-cycle data completion pulse
stall_if  out  1  i_req && !i_done
stall_mem  out  1  d_req && !d_done
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  4  memory byte enables (0 on reads)
mem_en  out  1  memory access active
mem_rdata  in  DATA_W  memory read data, valid in last BUSY cycle

Behaviour:
- Reset (async, any time, including mid-access): state IDLE, counter 0, all outputs 0, i_rdata/d_rdata 0, flush-pending flag 0, streak counter 0. Any in-flight access is abandoned with no done pulse.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: if d_req, go to BUSY_D; else if i_req, go to BUSY_I; else stay. Data beats fetch because the MEM-stage instruction is older. Requester signals are sampled at the edge; address, data, and we are latched into internal registers at grant.
- BUSY_x: mem_en=1 and mem_addr/wdata/wstrb are driven from the latched values for exactly LATENCY cycles. The counter loads LATENCY-1 at grant and decrements each cycle. In the cycle with counter==0, mem_rdata is captured into i_rdata or d_rdata (loads only; stores leave d_rdata unchanged), and the next state is IDLE.
- Completion: the x_done pulse is asserted for exactly one cycle, on the first IDLE cycle after BUSY. The arbiter may grant again on that same edge, so back-to-back throughput is LATENCY+1 cycles per access.
- if_flush asserted during BUSY_I, or in the done cycle, sets the flush flag. The memory access completes, i_rdata is not updated, and i_done is suppressed. if_flush in IDLE has no effect.
- Withdrawn requests (req low at the grant edge) are never granted. Requesters must not drop req while BUSY for them, except fetch under if_flush.
- stall_if/stall_mem are combinational. With i_req and d_req rising together, stall_if is held until the data access finishes and the fetch then finishes.
- Simultaneous if_flush and d_req in IDLE: data is granted; the flush is ignored.

Optional Feature:
ARB_FAIRNESS_EN: a streak counter counts consecutive BUSY_D grants made while i_req=1. When it reaches MAX_D_STREAK, the next IDLE grant goes to fetch if i_req, and the counter is cleared on any fetch grant. Without the macro, data always has strict priority and the streak logic is absent.

Test Plan:
- Single load: d_req=1, d_we=0, d_addr=0x100, mem returns 0xDEADBEEF, LATENCY=2 -> mem_en high 2 cycles, d_done pulses at cycle 3, d_rdata=0xDEADBEEF, stall_mem=1 for cycles 0-2.
- Simultaneous i_req (addr 0x0) and d_req store (0x200, wdata 0x12345678, wstrb 0xF) -> store first with mem_wstrb=0xF, d_done at cycle 3; fetch granted at cycle 3, i_done at cycle 6; stall_if=1 for cycles 0-5.
- Fetch flush: i_req 0x40, if_flush pulse in cycle 1 -> mem_en still 2 cycles, no i_done, i_rdata unchanged.
- Reset mid-access: rst asserted in the 2nd BUSY_D cycle -> outputs 0 immediately, no d_done; after release, a repeated request completes normally.
- LATENCY=1 back-to-back fetches at 0x0, 0x4 -> i_done every 2 cycles, mem_addr 0x0 then 0x4.
- With ARB_FAIRNESS_EN, MAX_D_STREAK=2, d_req and i_req held -> grant order D, D, I, D, D, I.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-ported unified memory arbiter between fetch (IF) and load/store (MEM) requesters.
// Define ARB_FAIRNESS_EN to bound consecutive data grants while a fetch is waiting.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LATENCY      = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (DATA_W != 32 || LATENCY < 1 || MAX_D_STREAK < 1) begin : g_param_check
        $error("mem_port_arbiter: DATA_W must be 32, LATENCY and MAX_D_STREAK must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic             flush_pend;
    logic             i_done_q;
    logic             grant_i;
    logic             grant_d;

`ifdef ARB_FAIRNESS_EN
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    logic [STREAK_W-1:0] streak;
    logic                fetch_turn;

    assign fetch_turn = (streak >= STREAK_W'(MAX_D_STREAK));
    assign grant_d    = d_req && !(fetch_turn && i_req);
`else
    assign grant_d    = d_req;
`endif
    assign grant_i    = i_req && !grant_d;

    // A flush in the completion cycle still has to swallow the already-registered pulse.
    assign i_done    = i_done_q && !if_flush;
    assign stall_if  = i_req && !i_done;
    assign stall_mem = d_req && !d_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            flush_pend <= 1'b0;
            i_done_q   <= 1'b0;
            d_done     <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
`ifdef ARB_FAIRNESS_EN
            streak     <= '0;
`endif
        end else begin
            i_done_q <= 1'b0;
            d_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= BUSY_D;
                        cnt       <= CNT_W'(LATENCY - 1);
                        lat_we    <= d_we;
                        mem_en    <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_we ? d_wstrb : 4'h0;
`ifdef ARB_FAIRNESS_EN
                        // grant_d with i_req implies streak < MAX_D_STREAK, so no overflow
                        streak    <= i_req ? streak + 1'b1 : '0;
`endif
                    end else if (grant_i) begin
                        state      <= BUSY_I;
                        cnt        <= CNT_W'(LATENCY - 1);
                        flush_pend <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_addr   <= i_addr;
                        mem_wdata  <= '0;
                        mem_wstrb  <= '0;
`ifdef ARB_FAIRNESS_EN
                        streak     <= '0;
`endif
                    end
                end
                BUSY_I: begin
                    if (if_flush) flush_pend <= 1'b1;
                    if (cnt == '0) begin
                        if (!(flush_pend || if_flush)) begin
                            i_rdata  <= mem_rdata;
                            i_done_q <= 1'b1;
                        end
                        flush_pend <= 1'b0;
                        state      <= IDLE;
                        mem_en     <= 1'b0;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                        mem_wstrb  <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BUSY_D: begin
                    if (cnt == '0) begin
                        if (!lat_we) d_rdata <= mem_rdata;
                        d_done    <= 1'b1;
                        state     <= IDLE;
                        mem_en    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
